string_match: RTL and testbench
===============================

# string_match

Command-string recognizer that sits behind a UART receiver. It accepts one byte per `valid` pulse and accumulates a line until carriage return (0x0D). It then compares the line against the keywords `start`, `stop` and `hitsz`, and transmits a two-byte reply code on its own UART transmitter (8N1).

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: transmit baud rate.
- `DIVIDER`, CLK_FREQ/BAUD_RATE (10416): clocks per UART bit.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (rst=0 resets).
- `valid`  in  1  one-cycle strobe; `recv_data` is valid this cycle.
- `recv_data`  in  8  received byte.
- `uart_tx`  out  1  serial output: 8N1, LSB first, idle high.

## Operation
- **Line buffer:** 8 bytes plus a 4-bit length counter and an overflow flag.
- **Non-CR byte with `valid`=1:**
  - If length < 8: store the byte at index `length` and increment `length`.
  - Otherwise: set overflow.
- **CR byte with `valid`=1:** classify the line, then clear the buffer, length and overflow in the same cycle.
- **Classification:** exact, case-sensitive match on both length and content. Overflow forces "unmatched".
  - `start` (73 74 61 72 74) -> code 0x31 (`1`).
  - `stop` (73 74 6F 70) -> code 0x32 (`2`).
  - `hitsz` (68 69 74 73 7A) -> code 0x33 (`3`).
  - Anything else, including an empty line, a prefix or superset of a keyword, or overflow -> code 0x30 (`0`).
- **Reply:** the code byte followed by 0x0D, sent back-to-back.
- **Pending register:** holds one code.
  - A classification while the transmitter is idle starts the reply immediately.
  - A classification while a reply is in progress is stored as pending. A newer one overwrites an older pending code.
  - A pending code is sent right after the current reply's CR stop bit ends.
- **Transmitter FSM:** IDLE -> START -> DATA (bits 0..7) -> STOP -> (second byte ? START : IDLE).
  - Each state/bit lasts exactly `DIVIDER` clocks.
  - `uart_tx` is driven from a register (glitch-free).
- **Reception during transmission:** byte reception continues; buffer logic is independent of the transmitter.
- **Ignored input:** bytes with `valid`=0 are ignored. `recv_data` is never sampled outside a `valid` cycle.

## Timing
- **Reset values:** `uart_tx`=1; FSM=IDLE; length=0; overflow=0; pending cleared; bit and baud counters=0.
- **Reset mid-transmission:** the frame aborts immediately and `uart_tx` returns high asynchronously.
- **Reply latency:** the cycle after the CR-`valid` cycle, `uart_tx` falls (start bit), provided the transmitter is idle.
- **Reply duration:** 2 bytes x 10 bits x DIVIDER = 208320 clocks (~2.083 ms at default parameters).
- **Byte sequencing:** no idle gap between the code byte's stop bit and the CR's start bit.
- **Idle after reply:** after the CR stop bit, `uart_tx` stays high unless a pending code exists. If one exists, its start bit begins the next cycle.
- **Buffer boundary:**
  - `valid` with a non-CR byte when length=7 stores the byte (length becomes 8).
  - The next non-CR byte sets overflow; the buffer contents stay unchanged.
- **Strobe spacing:** consecutive `valid` pulses may be as close as 1 cycle apart; every pulse is processed.

## Test plan
- **`start` line:** reset low 10 cycles, then send `s t a r t CR` (each `valid` one cycle, 10 bit-times apart) -> `uart_tx` frames 0x31 then 0x0D, each bit 10416 clocks, LSB first.
- **`stop` and `hitsz`:**
  - `s t o p CR` -> 0x32, 0x0D.
  - `h i t s z CR` -> 0x33, 0x0D.
  - The line buffer is cleared between commands, so the prior line does not affect the result.
- **Unmatched lines:**
  - `x y z CR` -> 0x30, 0x0D.
  - `sta CR` -> 0x30, 0x0D.
  - `starts CR` -> 0x30, 0x0D.
  - Empty line (CR only) -> 0x30, 0x0D.
- **Overflow:** 9 bytes `abcdefghi` then CR -> 0x30, 0x0D. A following `stop CR` -> 0x32, confirming the buffer cleared.
- **Overlap:** send `start CR`, then `stop CR` fully within the first reply -> `1 CR` immediately followed by `2 CR`, with no idle gap.
- **Reset mid-frame:** assert rst=0 during the code byte's data bits -> `uart_tx`=1 at once. After release, `hitsz CR` -> 0x33, 0x0D.

Source files
------------

// File: rtl/string_match.sv
// Command-line recognizer: buffers received bytes up to CR, classifies the line
// against start/stop/hitsz and replies with a code byte plus CR on an 8N1 transmitter.
module string_match #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DIVIDER   = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] recv_data,
  output logic       uart_tx
);

  localparam int              CNT_W     = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVIDER - 1);
  localparam logic [7:0]      CR        = 8'h0D;

  // Keywords packed with byte 0 in the least significant position.
  localparam logic [39:0] KW_START = 40'h74_72_61_74_73;
  localparam logic [31:0] KW_STOP  = 32'h70_6F_74_73;
  localparam logic [39:0] KW_HITSZ = 40'h7A_73_74_69_68;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  logic [63:0] line_q;
  logic [3:0]  len_q, len_d;
  logic        ovf_q, ovf_d;

  logic        cr_fire;
  logic        byte_fire;
  logic        store_en;
  logic [7:0]  class_code;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic             second_q, second_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tx_q, tx_d;

  logic             baud_end;
  logic             frame_done;
  logic             tx_free;
  logic [7:0]       cur_byte_d;

  assign cr_fire   = valid && (recv_data == CR);
  assign byte_fire = valid && (recv_data != CR);
  assign store_en  = byte_fire && !len_q[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else if (cr_fire) begin
      line_q <= '0;
    end else if (store_en) begin
      line_q[len_q[2:0]*8 +: 8] <= recv_data;
    end
  end

  always_comb begin
    len_d = len_q;
    ovf_d = ovf_q;
    if (cr_fire) begin
      len_d = 4'd0;
      ovf_d = 1'b0;
    end else if (byte_fire) begin
      if (!len_q[3]) len_d = len_q + 4'd1;
      else           ovf_d = 1'b1;
    end
  end

  // Exact match on length and content; overflow always classifies as unmatched.
  always_comb begin
    class_code = 8'h30;
    if (!ovf_q) begin
      if (len_q == 4'd5 && line_q[39:0] == KW_START)      class_code = 8'h31;
      else if (len_q == 4'd4 && line_q[31:0] == KW_STOP)  class_code = 8'h32;
      else if (len_q == 4'd5 && line_q[39:0] == KW_HITSZ) class_code = 8'h33;
    end
  end

  assign baud_end   = (baud_q == BAUD_LAST);
  assign frame_done = (state_q == S_STOP) && baud_end && second_q;
  assign tx_free    = (state_q == S_IDLE) || frame_done;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    second_d   = second_q;
    code_d     = code_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    case (state_q)
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!second_q) begin
            state_d  = S_START;
            second_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A fresh classification supersedes any older pending code.
    if (cr_fire) begin
      if (tx_free) begin
        state_d    = S_START;
        baud_d     = '0;
        second_d   = 1'b0;
        code_d     = class_code;
        pend_vld_d = 1'b0;
      end else begin
        pend_d     = class_code;
        pend_vld_d = 1'b1;
      end
    end else if (tx_free && pend_vld_q) begin
      state_d    = S_START;
      baud_d     = '0;
      second_d   = 1'b0;
      code_d     = pend_q;
      pend_vld_d = 1'b0;
    end
  end

  // Output bit is derived from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    cur_byte_d = second_d ? CR : code_d;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= 4'd0;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      second_q   <= 1'b0;
      code_q     <= 8'h00;
      pend_q     <= 8'h00;
      pend_vld_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      second_q   <= second_d;
      code_q     <= code_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_string_match.sv
// Directed bench for string_match: sends command lines and decodes the serial replies
// at fixed bit-centre times relative to the observed start bit.
module tb_string_match;

  localparam int DIV = 8;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] recv_data = 8'h0D;
  logic       uart_tx;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  string_match #(
    .CLK_FREQ (80),
    .BAUD_RATE(10),
    .DIVIDER  (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .recv_data(recv_data),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int t);
    if (cyc > t) chk("late_sample", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  // Idle cycles drive CR on the data bus so that sampling outside valid is caught.
  task automatic drive(input logic [7:0] b);
    recv_data = b;
    valid     = 1'b1;
    @(negedge clk);
    valid     = 1'b0;
    recv_data = 8'h0D;
  endtask

  task automatic send_line(input string s, input bit burst, output int t0);
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i]);
      if (!burst) @(negedge clk);
    end
    drive(8'h0D);
    t0 = cyc;
  endtask

  task automatic check_reply(input string tag, input int t0, input logic [7:0] code,
                             input bit skip_start);
    logic [7:0] b;
    logic [9:0] frame;
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? code : 8'h0D;
      frame = '0;
      for (int k = 0; k < 10; k++) begin
        if (f == 0 && k == 0 && skip_start) begin
          frame[k] = 1'b0;
        end else begin
          wait_until(t0 + f * FRAME + k * DIV + DIV / 2);
          frame[k] = uart_tx;
        end
      end
      chk({tag, (f == 0) ? "_code" : "_cr"}, {22'd0, frame}, {22'd0, 1'b1, b, 1'b0});
    end
  endtask

  task automatic cmd(input string tag, input string s, input logic [7:0] code);
    int t0;
    send_line(s, 1'b0, t0);
    chk({tag, "_lat"}, {31'd0, uart_tx}, 32'd0);
    check_reply(tag, t0, code, 1'b0);
    wait_until(t0 + 2 * FRAME + 3);
    chk({tag, "_idle"}, {31'd0, uart_tx}, 32'd1);
  endtask

  initial begin
    int t0;
    int t1;

    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx", {31'd0, uart_tx}, 32'd1);

    cmd("start", "start", 8'h31);
    cmd("stop", "stop", 8'h32);
    cmd("hitsz", "hitsz", 8'h33);
    cmd("xyz", "xyz", 8'h30);
    cmd("prefix", "sta", 8'h30);
    cmd("superset", "starts", 8'h30);
    cmd("empty", "", 8'h30);
    cmd("case", "Start", 8'h30);
    cmd("full8", "abcdefgh", 8'h30);
    cmd("ovf", "abcdefghi", 8'h30);
    cmd("after_ovf", "stop", 8'h32);

    // Second command arrives during the first reply and follows with no gap.
    send_line("start", 1'b0, t0);
    chk("ovl_lat", {31'd0, uart_tx}, 32'd0);
    send_line("stop", 1'b1, t1);
    check_reply("ovl1", t0, 8'h31, 1'b1);
    check_reply("ovl2", t0 + 2 * FRAME, 8'h32, 1'b0);
    wait_until(t0 + 4 * FRAME + 3);
    chk("ovl_idle", {31'd0, uart_tx}, 32'd1);

    // Newer pending code overwrites the older one.
    send_line("start", 1'b0, t0);
    chk("pend_lat", {31'd0, uart_tx}, 32'd0);
    send_line("stop", 1'b1, t1);
    send_line("hitsz", 1'b1, t1);
    check_reply("pend1", t0, 8'h31, 1'b1);
    check_reply("pend2", t0 + 2 * FRAME, 8'h33, 1'b0);
    wait_until(t0 + 4 * FRAME + 3);
    chk("pend_idle", {31'd0, uart_tx}, 32'd1);

    // Reset during data bit 1 of 0x31 (a zero bit) must raise the line immediately.
    send_line("start", 1'b0, t0);
    chk("mid_lat", {31'd0, uart_tx}, 32'd0);
    wait_until(t0 + 2 * DIV + DIV / 2);
    chk("mid_pre", {31'd0, uart_tx}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_async", {31'd0, uart_tx}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    chk("mid_aborted", {31'd0, uart_tx}, 32'd1);
    cmd("rst_hitsz", "hitsz", 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
